// File: rtl/rsflop_busy_sequencer.sv
// rsflop_busy_sequencer: upstream driver for the set/reset busy flop macrocell.
// Counts outstanding transactions from start/done pulses and issues one-cycle
// s (count leaves zero) and r (count returns to zero) pulses. After each r
// pulse a gap timer holds off the next s for GAP_CYCLES cycles.
// Optional build macro: RSFLOP_SEQ_STICKY_ERR_EN makes err_ovf/err_unf sticky
// until reset; without it they are one-cycle pulses.
module rsflop_busy_sequencer #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned MAX_OUT    = 15,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned GAP_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  output logic             s,
  output logic             r,
  output logic [CNT_W-1:0] count,
  output logic             in_gap,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [GAP_W-1:0]   timer_q, timer_nxt;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               s_q, s_nxt;
  logic               r_q, r_nxt;
  logic               in_gap_q, in_gap_nxt;
  logic               err_ovf_q, err_ovf_nxt;
  logic               err_unf_q, err_unf_nxt;

  logic               start_only_c;
  logic               done_only_c;
  logic               ovf_c;
  logic               unf_c;

  // Classify this cycle's request; simultaneous start&done cancel out.
  always_comb begin
    start_only_c = start & ~done;
    done_only_c  = done & ~start;
    ovf_c        = start_only_c && (count_q == CNT_MAX);
    unf_c        = done_only_c && (count_q == CNT_ZERO);
  end

  // Next outstanding count; rejected requests leave it unchanged.
  always_comb begin
    count_nxt = count_q;
    if (start_only_c && !ovf_c) begin
      count_nxt = count_q + CNT_ONE;
    end else if (done_only_c && !unf_c) begin
      count_nxt = count_q - CNT_ONE;
    end
  end

  // Sequencer next state and pulse generation; s and r are never both set.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_nxt != CNT_ZERO) begin
          s_nxt     = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (count_nxt == CNT_ZERO) begin
          r_nxt = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
            timer_nxt = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        // Expiry on the timer==1 edge; a zero timer is treated as expired.
        if (timer_q <= GAP_ONE) begin
          timer_nxt = GAP_ZERO;
          if (count_nxt != CNT_ZERO) begin
            s_nxt     = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          timer_nxt = timer_q - GAP_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = GAP_ZERO;
      end
    endcase
    in_gap_nxt = (state_nxt == ST_GAP);
  end

  // Error flag next values.
  always_comb begin
`ifdef RSFLOP_SEQ_STICKY_ERR_EN
    err_ovf_nxt = err_ovf_q | ovf_c;
    err_unf_nxt = err_unf_q | unf_c;
`else
    err_ovf_nxt = ovf_c;
    err_unf_nxt = unf_c;
`endif
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= GAP_ZERO;
      count_q   <= CNT_ZERO;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      in_gap_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      timer_q   <= timer_nxt;
      count_q   <= count_nxt;
      s_q       <= s_nxt;
      r_q       <= r_nxt;
      in_gap_q  <= in_gap_nxt;
      err_ovf_q <= err_ovf_nxt;
      err_unf_q <= err_unf_nxt;
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign count   = count_q;
  assign in_gap  = in_gap_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_rsflop_busy_sequencer.sv
// Scoreboard bench for rsflop_busy_sequencer: three instances with
// GAP_CYCLES = 2 (default), 0 and 4. Stimulus pushes hand-computed expected
// outputs tagged with the cycle they must appear in; the monitor pops and
// compares on the falling edge of that cycle.
module tb_rsflop_busy_sequencer;

  localparam int unsigned NDUT = 3;

  typedef struct packed {
    logic       s;
    logic       r;
    logic [3:0] count;
    logic       in_gap;
    logic       eo;
    logic       eu;
  } exp_t;

  typedef struct {
    int   tag;
    int   dut;
    exp_t e;
  } item_t;

  logic       clk;
  logic       rst_v [NDUT];
  logic       st_v  [NDUT];
  logic       dn_v  [NDUT];
  logic       o_s   [NDUT];
  logic       o_r   [NDUT];
  logic [3:0] o_cnt [NDUT];
  logic       o_gap [NDUT];
  logic       o_eo  [NDUT];
  logic       o_eu  [NDUT];

  item_t q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  rsflop_busy_sequencer #(.CNT_W(4), .MAX_OUT(15), .GAP_CYCLES(2), .GAP_W(4)) u_a (
    .clk(clk), .reset(rst_v[0]), .start(st_v[0]), .done(dn_v[0]),
    .s(o_s[0]), .r(o_r[0]), .count(o_cnt[0]), .in_gap(o_gap[0]),
    .err_ovf(o_eo[0]), .err_unf(o_eu[0]));

  rsflop_busy_sequencer #(.CNT_W(4), .MAX_OUT(15), .GAP_CYCLES(0), .GAP_W(4)) u_b (
    .clk(clk), .reset(rst_v[1]), .start(st_v[1]), .done(dn_v[1]),
    .s(o_s[1]), .r(o_r[1]), .count(o_cnt[1]), .in_gap(o_gap[1]),
    .err_ovf(o_eo[1]), .err_unf(o_eu[1]));

  rsflop_busy_sequencer #(.CNT_W(4), .MAX_OUT(15), .GAP_CYCLES(4), .GAP_W(4)) u_c (
    .clk(clk), .reset(rst_v[2]), .start(st_v[2]), .done(dn_v[2]),
    .s(o_s[2]), .r(o_r[2]), .count(o_cnt[2]), .in_gap(o_gap[2]),
    .err_ovf(o_eo[2]), .err_unf(o_eu[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compare every expectation due this cycle; also watch s/r overlap.
  always @(negedge clk) begin
    exp_t act;
    item_t it;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      it = q.pop_front();
      act = {o_s[it.dut], o_r[it.dut], o_cnt[it.dut], o_gap[it.dut],
             o_eo[it.dut], o_eu[it.dut]};
      n_cmp = n_cmp + 1;
      if (it.tag != cyc || act !== it.e) begin
        n_err = n_err + 1;
        $display("FAIL dut%0d cyc%0d (due %0d): got s=%b r=%b cnt=%0d gap=%b eo=%b eu=%b, want s=%b r=%b cnt=%0d gap=%b eo=%b eu=%b",
                 it.dut, cyc, it.tag, act.s, act.r, act.count, act.in_gap, act.eo, act.eu,
                 it.e.s, it.e.r, it.e.count, it.e.in_gap, it.e.eo, it.e.eu);
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      if (o_s[d] === 1'b1 && o_r[d] === 1'b1) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL overlap dut%0d cyc%0d: s=1 r=1, want never both", d, cyc);
      end
    end
  end

  // Drive one vector into DUT d and queue the outputs expected next cycle.
  task automatic v(input int d, input bit rs, input bit st, input bit dn,
                   input bit es, input bit er, input int ec, input bit eg,
                   input bit eo, input bit eu);
    item_t it;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      rst_v[k] = 1'b0;
      st_v[k]  = 1'b0;
      dn_v[k]  = 1'b0;
    end
    rst_v[d] = rs;
    st_v[d]  = st;
    dn_v[d]  = dn;
    it.tag = cyc + 1;
    it.dut = d;
    it.e   = {es, er, 4'(ec), eg, eo, eu};
    q.push_back(it);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    item_t it;
    for (int k = 0; k < NDUT; k++) begin
      rst_v[k] = 1'b1;
      st_v[k]  = 1'b0;
      dn_v[k]  = 1'b0;
    end
    // Reset all instances together and check reset values.
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      it.tag = cyc + 1;
      it.dut = k;
      it.e   = '0;
      q.push_back(it);
    end

    // ---- DUT A, GAP_CYCLES=2 ----
    v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // no pulse right after reset
    // basic busy period: s, hold, r, two gap cycles, idle
    v(0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    v(0, 0, 0, 1,  0, 1, 0, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // start during gap: s held off until expiry
    v(0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(0, 0, 0, 1,  0, 1, 0, 1, 0, 0);
    v(0, 0, 1, 0,  0, 0, 1, 1, 0, 0);
    v(0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
    v(0, 0, 0, 1,  0, 1, 0, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // start&done at zero: nothing
    v(0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
    // fill to MAX_OUT
    for (int i = 0; i < 15; i++) v(0, 0, 1, 0,  (i == 0), 0, i + 1, 0, 0, 0);
    v(0, 0, 1, 1,  0, 0, 15, 0, 0, 0);  // start&done at max: hold, no error
    v(0, 0, 1, 0,  0, 0, 15, 0, 1, 0);  // overflow rejected
    v(0, 0, 0, 0,  0, 0, 15, 0, 0, 0);  // error was a single-cycle pulse
    // drain to zero
    for (int i = 0; i < 15; i++) v(0, 0, 0, 1,  0, (i == 14), 14 - i, (i == 14), 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1,  0, 0, 0, 0, 0, 1);   // underflow rejected
    v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // count returns to zero inside gap: no pulse at expiry
    v(0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(0, 0, 0, 1,  0, 1, 0, 1, 0, 0);
    v(0, 0, 1, 0,  0, 0, 1, 1, 0, 0);
    v(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // ---- DUT B, GAP_CYCLES=0: r and s on consecutive cycles ----
    v(1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(1, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    v(1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(1, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // ---- DUT C, GAP_CYCLES=4: reset in gap with count=3 ----
    v(2, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(2, 0, 0, 1,  0, 1, 0, 1, 0, 0);
    v(2, 0, 1, 0,  0, 0, 1, 1, 0, 0);
    v(2, 0, 1, 0,  0, 0, 2, 1, 0, 0);
    v(2, 0, 1, 0,  0, 0, 3, 1, 0, 0);
    v(2, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    v(2, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    v(2, 0, 1, 0,  1, 0, 1, 0, 0, 0);
    v(2, 0, 0, 0,  0, 0, 1, 0, 0, 0);

    // Quiesce and confirm every expectation was consumed.
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      st_v[k] = 1'b0;
      dn_v[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp = n_cmp + 1;
    if (q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
